// File: rtl/host_bus_master.sv
// Host-side initiator for the accelerator io_bus: feeds A/B words to the chip over valid/ready
// and writes captured results to external memory, sequencing chip start/done per layer.
module host_bus_master #(
    parameter int unsigned BUS_WIDTH          = 48,
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned FEATURE_MAP_WIDTH  = 128,
    parameter int unsigned FEATURE_MAP_HEIGHT = 128,
    parameter int unsigned OUTPUT_NB_CHANNELS = 16,
    parameter int unsigned EXT_MEM_HEIGHT     = 1 << 20,
    localparam int unsigned ADDR_W = $clog2(EXT_MEM_HEIGHT),
    localparam int unsigned XW     = $clog2(FEATURE_MAP_WIDTH),
    localparam int unsigned YW     = $clog2(FEATURE_MAP_HEIGHT),
    localparam int unsigned CW     = $clog2(OUTPUT_NB_CHANNELS),
    localparam int unsigned CNT_W  =
        $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS) + 1
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          cmd_start,
    input  logic [ADDR_W-1:0]             out_base,
    output logic                          busy,
    output logic                          layer_done,
    output logic                          dropped,
    input  logic                          src_a_valid,
    output logic                          src_a_ready,
    input  logic [BUS_WIDTH-1:0]          src_a_data,
    input  logic                          src_b_valid,
    output logic                          src_b_ready,
    input  logic [BUS_WIDTH-1:0]          src_b_data,
    output logic [BUS_WIDTH-1:0]          bus_out,
    output logic                          bus_oe,
    input  logic [BUS_WIDTH-1:0]          bus_in,
    output logic                          a_valid,
    input  logic                          a_ready,
    output logic                          b_valid,
    input  logic                          b_ready,
    input  logic                          output_valid,
    input  logic [XW-1:0]                 output_x,
    input  logic [YW-1:0]                 output_y,
    input  logic [CW-1:0]                 output_ch,
    output logic                          chip_start,
    input  logic                          chip_done,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [ACCUMULATION_WIDTH-1:0] mem_wdata,
    output logic [CNT_W-1:0]              out_count
);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDrain} state_e;

    state_e                          state_q, state_d;
    logic                            full_a_q, full_a_d, full_b_q, full_b_d;
    logic [BUS_WIDTH-1:0]            data_a_q, data_a_d, data_b_q, data_b_d;
    logic                            offer_q, offer_d, sel_q, sel_d, rr_q, rr_d;
    logic                            dropped_q, dropped_d, done_q, done_d;
    logic                            cap_q, cap_d;
    logic [ADDR_W-1:0]               base_q, base_d, addr_q, addr_d;
    logic [ACCUMULATION_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]                count_q, count_d;

    logic run, idle, cap, offer_any, sel, fire_a, fire_b, fire, load_a, load_b;
    logic [ADDR_W-1:0] result_addr;
    logic unused_bus_hi;

    assign unused_bus_hi = ^bus_in[BUS_WIDTH-1:ACCUMULATION_WIDTH];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_start) state_d = StStart;
            StStart: state_d = StRun;
            StRun:   if (chip_done) state_d = StDrain;
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign idle = (state_q == StIdle);
    assign run  = (state_q == StRun);
    assign cap  = output_valid & (run | (state_q == StDrain));

    // A pending offer keeps its channel; otherwise pick the full slot, round-robin if both are.
    assign offer_any = offer_q | full_a_q | full_b_q;
    always_comb begin
        if (offer_q)                 sel = sel_q;
        else if (full_a_q & full_b_q) sel = rr_q;
        else                         sel = full_b_q;
    end

    assign a_valid     = offer_any & ~sel & ~cap;
    assign b_valid     = offer_any & sel & ~cap;
    assign bus_oe      = a_valid | b_valid;
    assign bus_out     = offer_any ? (sel ? data_b_q : data_a_q) : '0;
    assign fire_a      = a_valid & a_ready;
    assign fire_b      = b_valid & b_ready;
    assign fire        = fire_a | fire_b;
    assign src_a_ready = run & (~full_a_q | fire_a);
    assign src_b_ready = run & (~full_b_q | fire_b);
    assign load_a      = src_a_valid & src_a_ready;
    assign load_b      = src_b_valid & src_b_ready;

    assign result_addr = base_q + (ADDR_W'(output_ch) * ADDR_W'(FEATURE_MAP_HEIGHT)
                         + ADDR_W'(output_y)) * ADDR_W'(FEATURE_MAP_WIDTH) + ADDR_W'(output_x);

    always_comb begin
        full_a_d  = load_a | (full_a_q & ~fire_a);
        full_b_d  = load_b | (full_b_q & ~fire_b);
        data_a_d  = load_a ? src_a_data : data_a_q;
        data_b_d  = load_b ? src_b_data : data_b_q;
        offer_d   = offer_any & ~fire;
        sel_d     = sel;
        rr_d      = rr_q ^ fire;
        dropped_d = dropped_q;
        done_d    = (state_q == StDrain);
        base_d    = base_q;
        count_d   = count_q + CNT_W'(cap);
        cap_d     = cap;
        wdata_d   = cap ? bus_in[ACCUMULATION_WIDTH-1:0] : wdata_q;
        addr_d    = cap ? result_addr : addr_q;
        // Leaving DRAIN discards whatever the chip never accepted.
        if (state_q == StDrain) begin
            dropped_d = dropped_q | full_a_d | full_b_d;
            full_a_d  = 1'b0;
            full_b_d  = 1'b0;
            offer_d   = 1'b0;
        end
        if (idle && cmd_start) begin
            dropped_d = 1'b0;
            base_d    = out_base;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q   <= StIdle;
            full_a_q  <= 1'b0;
            full_b_q  <= 1'b0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            offer_q   <= 1'b0;
            sel_q     <= 1'b0;
            rr_q      <= 1'b0;
            dropped_q <= 1'b0;
            done_q    <= 1'b0;
            base_q    <= '0;
            count_q   <= '0;
            cap_q     <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            full_a_q  <= full_a_d;
            full_b_q  <= full_b_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            offer_q   <= offer_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            dropped_q <= dropped_d;
            done_q    <= done_d;
            base_q    <= base_d;
            count_q   <= count_d;
            cap_q     <= cap_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
        end
    end

    assign busy       = ~idle;
    assign chip_start = (state_q == StStart);
    assign layer_done = done_q;
    assign dropped    = dropped_q;
    assign mem_we     = cap_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign out_count  = count_q;

endmodule
